// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin request arbiter.
//   N_REQ          number of requesters (fixed at 8 in this revision)
//   ID_W           width of a requester index, clog2(N_REQ)
//   state_t        arbiter FSM encoding (IDLE=0, BUSY=1)
//   onehot_to_idx  converts a one-hot (or zero) vector to its binary index
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // OR-reduction encoder: exact for a one-hot input, returns 0 for all-zero.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between the requester bank and the arbiter.
//   req      requester bank -> arbiter, one level-sensitive bit per requester
//   gnt      arbiter -> bank/mux, one-hot grant (zero when no owner)
//   gnt_id   arbiter -> mux select, binary owner index (valid with gnt_vld)
//   gnt_vld  arbiter -> bank/mux, a grant is active this cycle
//   preempt  arbiter -> bank, pulse when a grant is removed by timeout
// Modport master is the arbiter side; slave is the requester-bank side.
interface rr_req_arbiter_if;

  logic [arb_pkg::N_REQ-1:0] req;
  logic [arb_pkg::N_REQ-1:0] gnt;
  logic [arb_pkg::ID_W-1:0]  gnt_id;
  logic                      gnt_vld;
  logic                      preempt;

  modport master (
    input  req,
    output gnt, gnt_id, gnt_vld, preempt
  );

  modport slave (
    output req,
    input  gnt, gnt_id, gnt_vld, preempt
  );

endinterface

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick.
//   req       request vector
//   ptr       highest-priority position for this pick
//   pick_id   first set bit of req searching upward from ptr, wrapping to 0
//   pick_vld  at least one request is set
// Two lowest-set-bit encoders: one on the requests at or above ptr, and one on
// the full request vector as the wrap-around fallback.
module rr_prio_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_vld
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] lo_masked;
  logic [N_REQ-1:0] lo_all;

  assign mask   = {N_REQ{1'b1}} << ptr;
  assign masked = req & mask;

  // x & -x isolates the lowest set bit, giving a one-hot priority result.
  assign lo_masked = masked & (~masked + N_REQ'(1));
  assign lo_all    = req & (~req + N_REQ'(1));

  assign pick_id  = (masked != '0) ? onehot_to_idx(lo_masked) : onehot_to_idx(lo_all);
  assign pick_vld = (req != '0);

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter sharing one resource between N_REQ requesters.
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   rr_req_arbiter_if.master: req in; gnt, gnt_id, gnt_vld, preempt out
// Parameters:
//   MAX_HOLD  max consecutive grant cycles per owner; 0 disables the limit
//   CNT_W     hold counter width; must be able to represent MAX_HOLD
// A grant is held while the owner keeps its request and the hold limit is not
// reached. Every release passes through one IDLE cycle, and the round-robin
// pointer moves to just past the released owner.
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  rr_req_arbiter_if.master  bus
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic              preempt_q, preempt_d;

  logic [ID_W-1:0]   pick_id;
  logic              pick_vld;
  logic              owner_req;
  logic              at_limit;

  rr_prio_pick u_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick_id  (pick_id),
    .pick_vld (pick_vld)
  );

  assign owner_req = bus.req[gnt_id_q];
  assign at_limit  = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    gnt_vld_d  = gnt_vld_q;
    preempt_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d      = N_REQ'(1) << pick_id;
          gnt_id_d   = pick_id;
          gnt_vld_d  = 1'b1;
          hold_cnt_d = CNT_W'(1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (!owner_req || at_limit) begin
          gnt_d      = '0;
          gnt_vld_d  = 1'b0;
          hold_cnt_d = '0;
          ptr_d      = gnt_id_q + ID_W'(1);
          state_d    = IDLE;
          // A voluntary drop wins over a coincident timeout: only flag
          // preemption when the owner still wanted the resource.
          preempt_d  = owner_req;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // updates from values sampled before the edge.
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      gnt_vld_q  <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
      preempt_q  <= preempt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: a table of directed vectors, hand
// sequences for timeout / reset / coincident release, then random requests
// compared cycle by cycle against a behavioural round-robin model.
module tb_rr_req_arbiter;

  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst;

  rr_req_arbiter_if bus ();

  rr_req_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       pre;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state: current owner (-1 = none), tenure length, pointer.
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_pre;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply inputs, take one rising edge, and settle just after it.
  task automatic tick(input logic r, input logic [7:0] q);
    rst     = r;
    bus.req = q;
    @(posedge clk);
    #1;
  endtask

  // Packed {preempt, vld, id, gnt}; id only matters while a grant is valid.
  function automatic logic [12:0] pk(input logic [7:0] g, input logic [2:0] id,
                                     input logic v, input logic p);
    return {p, v, (v ? id : 3'd0), g};
  endfunction

  function automatic logic [12:0] obs();
    return pk(bus.gnt, bus.gnt_id, bus.gnt_vld, bus.preempt);
  endfunction

  // From a cycle where a grant is visible, keep requesting q until a preempt
  // pulse appears; cnt counts visible grant cycles including the first one.
  task automatic run_to_timeout(input logic [7:0] q, input logic [7:0] g,
                                output int cnt, output bit seen);
    cnt  = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, q);
      if (bus.preempt) begin
        seen = 1'b1;
        break;
      end
      if (!(bus.gnt_vld && bus.gnt == g)) break;
      cnt++;
    end
  endtask

  task automatic model_step(input logic r, input logic [7:0] q);
    m_pre = 1'b0;
    if (r) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (q[idx]) begin
          m_owner = idx;
          m_held  = 1;
          break;
        end
      end
    end else if (!q[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_pre   = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  function automatic logic [12:0] model_out();
    if (m_owner < 0) return pk(8'h00, 3'd0, 1'b0, m_pre);
    return pk(8'(1 << m_owner), 3'(m_owner), 1'b1, 1'b0);
  endfunction

  initial begin
    int         cnt;
    bit         seen;
    logic [7:0] q;
    logic       r;

    rst     = 1'b1;
    bus.req = 8'h00;

    // Directed table: idle after reset, single requester, pointer moves,
    // wrap-around, non-owner request changes ignored.
    tbl.push_back('{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h18, 8'h10, 3'd4, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h09, 8'h01, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h0D, 8'h01, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h09, 8'h08, 3'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].req);
      check($sformatf("tbl[%0d]", i), 32'(obs()),
            32'(pk(tbl[i].gnt, tbl[i].id, tbl[i].vld, tbl[i].pre)));
      if (tbl[i].rst) check("tbl_rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    end

    // All requesting; each owner drops after two grant cycles -> 0..7,0.
    tick(1'b1, 8'h00);
    for (int o = 0; o < 9; o++) begin
      tick(1'b0, 8'hFF);
      check($sformatf("rr_grant%0d", o), 32'(obs()), 32'(pk(8'(1 << (o % 8)), 3'(o % 8), 1'b1, 1'b0)));
      tick(1'b0, 8'hFF);
      check($sformatf("rr_hold%0d", o), 32'(obs()), 32'(pk(8'(1 << (o % 8)), 3'(o % 8), 1'b1, 1'b0)));
      tick(1'b0, 8'hFF & ~8'(1 << (o % 8)));
      check($sformatf("rr_idle%0d", o), 32'(obs()), 32'(pk(8'h00, 3'd0, 1'b0, 1'b0)));
    end

    // Timeout: 16 grant cycles then a preempt pulse with the grant removed.
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h01);
    check("to_grant", 32'(obs()), 32'(pk(8'h01, 3'd0, 1'b1, 1'b0)));
    run_to_timeout(8'h01, 8'h01, cnt, seen);
    check("to_seen", 32'(seen), 32'd1);
    check("to_len", 32'(cnt), 32'd16);
    check("to_pulse", 32'(obs()), 32'(pk(8'h00, 3'd0, 1'b0, 1'b1)));
    tick(1'b0, 8'h01);
    check("to_regrant0", 32'(obs()), 32'(pk(8'h01, 3'd0, 1'b1, 1'b0)));
    run_to_timeout(8'h03, 8'h01, cnt, seen);
    check("to2_seen", 32'(seen), 32'd1);
    check("to2_len", 32'(cnt), 32'd16);
    tick(1'b0, 8'h03);
    check("to_next1", 32'(obs()), 32'(pk(8'h02, 3'd1, 1'b1, 1'b0)));

    // Reset during a grant, with the pointer away from zero beforehand.
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h02);
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h20);
    check("rst_pre", 32'(obs()), 32'(pk(8'h20, 3'd5, 1'b1, 1'b0)));
    tick(1'b1, 8'h20);
    check("rst_outs", 32'(obs()), 32'(pk(8'h00, 3'd0, 1'b0, 1'b0)));
    check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    tick(1'b0, 8'h21);
    check("rst_ptr0", 32'(obs()), 32'(pk(8'h01, 3'd0, 1'b1, 1'b0)));

    // Owner drops on the cycle the limit is reached: normal release.
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h01);
    for (int i = 0; i < 15; i++) tick(1'b0, 8'h01);
    check("both_held16", 32'(obs()), 32'(pk(8'h01, 3'd0, 1'b1, 1'b0)));
    tick(1'b0, 8'h00);
    check("both_release", 32'(obs()), 32'(pk(8'h00, 3'd0, 1'b0, 1'b0)));
    tick(1'b0, 8'h03);
    check("both_ptr", 32'(obs()), 32'(pk(8'h02, 3'd1, 1'b1, 1'b0)));

    // Random requests against the behavioural model.
    tick(1'b1, 8'h00);
    model_step(1'b1, 8'h00);
    q = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) q = 8'h00;
      else if ($urandom_range(0, 3) == 0) q = 8'($urandom);
      else if (m_owner >= 0 && $urandom_range(0, ((c / 250) % 2 != 0) ? 30 : 3) == 0)
        q[m_owner] = 1'b0;
      tick(r, q);
      model_step(r, q);
      check("rand", 32'(obs()), 32'(model_out()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
